// File: rtl/ps_arbiter_pkg.sv
// Shared definitions for the Program Storage stage arbiter: packet/counter
// defaults and the handshake FSM state encoding.
package ps_arbiter_pkg;

    localparam int PS_PACK_W = 52;
    localparam int PS_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RTZ  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ps_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the requester named by the priority bit.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       valid,
    output logic       idx
);

    always_comb begin
        valid = |req;
        idx   = (req == 2'b11) ? prio : req[1];
    end

endmodule

// File: rtl/ps_arbiter.sv
// Two-input four-phase arbiter feeding the Program Storage stage, with a
// registered packet path and per-requester completed-grant counters.
module ps_arbiter
    import ps_arbiter_pkg::*;
#(
    parameter int PACK_W = PS_PACK_W,
    parameter int CNT_W  = PS_CNT_W
) (
    input  logic              CLK,
    input  logic              MR_n,
    input  logic              Send_in0,
    input  logic              Send_in1,
    input  logic [PACK_W-1:0] PACKET_IN0,
    input  logic [PACK_W-1:0] PACKET_IN1,
    output logic              Ack_out0,
    output logic              Ack_out1,
    output logic              Send_out,
    output logic [PACK_W-1:0] PACKET_OUT,
    input  logic              Ack_in,
    output logic [CNT_W-1:0]  GCNT0,
    output logic [CNT_W-1:0]  GCNT1
);

    arb_state_e              state_reg, state_next;
    logic                    w_reg, w_next;
    logic                    p_reg, p_next;
    logic                    send_reg, send_next;
    logic [1:0]              ack_reg, ack_next;
    logic [PACK_W-1:0]       pkt_reg, pkt_next;
    logic [1:0][CNT_W-1:0]   gcnt_reg, gcnt_next;
    logic [1:0]              cnt_inc;
    logic [1:0]              send_in;
    logic                    pick_valid;
    logic                    pick_idx;

    assign send_in = {Send_in1, Send_in0};

    rr_pick2 u_pick (
        .req   (send_in),
        .prio  (p_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State register: every output is taken straight from here.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state_reg <= ST_IDLE;
            w_reg     <= 1'b0;
            p_reg     <= 1'b0;
            send_reg  <= 1'b0;
            ack_reg   <= 2'b00;
            pkt_reg   <= '0;
            gcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            p_reg     <= p_next;
            send_reg  <= send_next;
            ack_reg   <= ack_next;
            pkt_reg   <= pkt_next;
            gcnt_reg  <= gcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        p_next     = p_reg;
        send_next  = send_reg;
        ack_next   = ack_reg;
        pkt_next   = pkt_reg;
        cnt_inc    = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    w_next     = pick_idx;
                    pkt_next   = pick_idx ? PACKET_IN1 : PACKET_IN0;
                    send_next  = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // A winner that drops its request here still gets a full handshake.
                if (Ack_in) begin
                    send_next        = 1'b0;
                    ack_next[w_reg]  = 1'b1;
                    state_next       = ST_RTZ;
                end
            end
            ST_RTZ: begin
                if (!Ack_in && !send_in[w_reg]) begin
                    ack_next         = 2'b00;
                    p_next           = ~w_reg;
                    cnt_inc[w_reg]   = 1'b1;
                    state_next       = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        for (int i = 0; i < 2; i++) begin
            gcnt_next[i] = gcnt_reg[i] + CNT_W'(cnt_inc[i]);
        end
    end

    always_comb begin
        Send_out   = send_reg;
        Ack_out0   = ack_reg[0];
        Ack_out1   = ack_reg[1];
        PACKET_OUT = pkt_reg;
        GCNT0      = gcnt_reg[0];
        GCNT1      = gcnt_reg[1];
    end

endmodule
